// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Data-port bundle between the CPU (master) and the multi-cycle data
//   memory (slave).
//   master drives : mRD, mWR, DAddr[31:0], DataIn[31:0]
//   slave drives  : DataOut[31:0], Ready, Busy, Err
interface data_mem_responder_if;
  logic        mRD;
  logic        mWR;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Busy;
  logic        Err;

  modport master (
    output mRD, mWR, DAddr, DataIn,
    input  DataOut, Ready, Busy, Err
  );

  modport slave (
    input  mRD, mWR, DAddr, DataIn,
    output DataOut, Ready, Busy, Err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side end of the CPU data port. Captures one read or write,
//   inserts WAIT_CYCLES wait states, then completes with a one-cycle Ready.
//   Ports:
//     CLK    in   clock, rising edge
//     Reset  in   asynchronous active-low reset
//     bus    slave modport of data_mem_responder_if
//            (mRD, mWR, DAddr, DataIn in; DataOut, Ready, Busy, Err out)
//   Parameters: DEPTH_WORDS (power of two, >= 2), WAIT_CYCLES (0..15).
//   Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
//   on Err, suppress misaligned writes and hold DataOut on misaligned reads.
//   Without it Err stays 0 and DAddr[1:0] is ignored.
//
//   state  | meaning
//   IDLE   | waiting for mRD/mWR; captures the request
//   WAIT   | counting down wait states, requests ignored
//   RESP   | Ready high for this one cycle, requests ignored
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic              misal_q, misal_d;
  logic [31:0]       dout_q, dout_d;
  logic              mem_we;

  logic [31:0]       mem [DEPTH_WORDS];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
      misal_q <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      misal_q <= misal_d;
      dout_q  <= dout_d;
    end
  end

  // The commit uses the _d view of the request so that with WAIT_CYCLES==0
  // the capture edge and the commit edge coincide and still see live inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = wr_q;
    misal_d = misal_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mRD || bus.mWR) begin
          idx_d  = bus.DAddr[IDX_W+1:2];
          data_d = bus.DataIn;
          wr_d   = bus.mWR;
`ifdef DMEM_ALIGN_CHECK_EN
          misal_d = (bus.DAddr[1:0] != 2'b00);
`else
          misal_d = 1'b0;
`endif
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_RESP) && (state_q != S_RESP) && !misal_d) begin
      // Reset gating keeps a request held through reset from writing memory.
      if (wr_d) mem_we = Reset;
      else      dout_d = mem[idx_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx_d] <= data_d;
  end

  // misal_q is constant 0 without the alignment check, so Err is tied low.
  always_comb begin
    bus.Ready   = (state_q == S_RESP);
    bus.Busy    = (state_q != S_IDLE);
    bus.Err     = (state_q == S_RESP) && misal_q;
    bus.DataOut = dout_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  data_mem_responder_if ia();
  data_mem_responder_if ib();

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_w2 (
    .CLK(CLK), .Reset(Reset), .bus(ia.slave)
  );
  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(CLK), .Reset(Reset), .bus(ib.slave)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; request is dropped right after capture.
  task automatic acc_a(input string tag, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_dout, input bit exp_err);
    logic [31:0] dout_before;
    int lat;
    bit seen, busy_ok, dout_ok;
    dout_before = ia.DataOut;
    ia.mRD = rd; ia.mWR = wr; ia.DAddr = addr; ia.DataIn = wdata;
    @(posedge CLK); #1;
    ia.mRD = 1'b0; ia.mWR = 1'b0; ia.DAddr = 32'hFFFF_FFFC; ia.DataIn = 32'h5555_5555;
    lat = 0; seen = 1'b0; busy_ok = 1'b1; dout_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ia.Busy !== 1'b1) busy_ok = 1'b0;
      if (ia.Ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (ia.DataOut !== dout_before || ia.Err !== 1'b0) dout_ok = 1'b0;
      lat++;
      @(posedge CLK); #1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_hold"}, 32'(dout_ok), 32'd1);
    chk({tag, "_err"}, 32'(ia.Err), 32'(exp_err));
    chk({tag, "_dout"}, ia.DataOut, exp_dout);
    @(posedge CLK); #1;
    chk({tag, "_idle"}, 32'({ia.Ready, ia.Busy, ia.Err}), 32'd0);
  endtask

  // Three accesses to 0x00/0x04/0x08 on the WAIT_CYCLES=0 instance, request held high.
  task automatic stream_b(input string tag, input bit wr,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] wd [3];
    logic [31:0] ed [3];
    int k;
    wd = '{d0, d1, d2};
    ed = '{e0, e1, e2};
    k = 0;
    ib.mRD = !wr; ib.mWR = wr; ib.DAddr = 32'd0; ib.DataIn = wd[0];
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("%s_rdy%0d", tag, c), 32'(ib.Ready), 32'((c % 2) == 0));
      if (ib.Ready === 1'b1 && k < 3) begin
        chk($sformatf("%s_dout%0d", tag, k), ib.DataOut, ed[k]);
        k++;
        if (k == 3) begin
          ib.mRD = 1'b0; ib.mWR = 1'b0;
        end else begin
          ib.DAddr = 32'(4 * k); ib.DataIn = wd[k];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rdy;
    bit busy_ok, drop;
    logic [31:0] d10, d11;

    Reset = 1'b0;
    ia.mRD = 1'b0; ia.mWR = 1'b0; ia.DAddr = 32'd0; ia.DataIn = 32'd0;
    ib.mRD = 1'b0; ib.mWR = 1'b0; ib.DAddr = 32'd0; ib.DataIn = 32'd0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_a_dout", ia.DataOut, 32'd0);
    chk("rst_a_flags", 32'({ia.Ready, ia.Busy, ia.Err}), 32'd0);
    chk("rst_b_dout", ib.DataOut, 32'd0);
    chk("rst_b_flags", 32'({ib.Ready, ib.Busy, ib.Err}), 32'd0);
    Reset = 1'b1;
    @(posedge CLK); #1;

    acc_a("wr08",   1'b0, 1'b1, 32'h08,  32'hDEAD_BEEF, 32'h0,         1'b0);
    acc_a("rd08",   1'b1, 1'b0, 32'h08,  32'h0,         32'hDEAD_BEEF, 1'b0);
    acc_a("wr100",  1'b0, 1'b1, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    acc_a("rd000",  1'b1, 1'b0, 32'h000, 32'h0,         32'h1234_5678, 1'b0);
    acc_a("both20", 1'b1, 1'b1, 32'h20,  32'hA5A5_A5A5, 32'h1234_5678, 1'b0);
    acc_a("rd20",   1'b1, 1'b0, 32'h20,  32'h0,         32'hA5A5_A5A5, 1'b0);
    acc_a("wr10",   1'b0, 1'b1, 32'h10,  32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b0);

    // Abort a write of 0xFFFFFFFF to 0x10 with reset while in WAIT.
    ia.mWR = 1'b1; ia.DAddr = 32'h10; ia.DataIn = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    ia.mWR = 1'b0;
    @(posedge CLK); #1;
    chk("abort_inwait", 32'(ia.Busy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("abort_dout", ia.DataOut, 32'd0);
    chk("abort_flags", 32'({ia.Ready, ia.Busy, ia.Err}), 32'd0);
    n_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (ia.Ready === 1'b1) n_rdy++;
    end
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (ia.Ready === 1'b1) n_rdy++;
    end
    chk("abort_noready", 32'(n_rdy), 32'd0);
    acc_a("rd10_after_abort", 1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Alignment behaviour.
    acc_a("wr0A", 1'b0, 1'b1, 32'h0A, 32'h1111_1111, 32'hCAFE_F00D, ALIGN_EN);
    d10 = ALIGN_EN ? 32'hDEAD_BEEF : 32'h1111_1111;
    acc_a("rd08_align", 1'b1, 1'b0, 32'h08, 32'h0, d10, 1'b0);
    d11 = ALIGN_EN ? d10 : 32'hA5A5_A5A5;
    acc_a("rd21", 1'b1, 1'b0, 32'h21, 32'h0, d11, ALIGN_EN);
    acc_a("wr24", 1'b0, 1'b1, 32'h24, 32'h2424_2424, d11, 1'b0);

    // Requests held during WAIT and RESP must be ignored.
    ia.mRD = 1'b1; ia.DAddr = 32'h20;
    @(posedge CLK); #1;
    ia.mRD = 1'b1; ia.mWR = 1'b1; ia.DAddr = 32'h24; ia.DataIn = 32'h7777_7777;
    n_rdy = 0; busy_ok = 1'b1; drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ia.Ready === 1'b1) begin
        n_rdy++;
        chk("ign_dout", ia.DataOut, 32'hA5A5_A5A5);
        drop = 1'b1;
      end else if (drop) begin
        ia.mRD = 1'b0; ia.mWR = 1'b0;
      end
      if (i < 3 && ia.Busy !== 1'b1) busy_ok = 1'b0;
      if (i >= 3 && ia.Busy !== 1'b0) busy_ok = 1'b0;
      @(posedge CLK); #1;
    end
    ia.mRD = 1'b0; ia.mWR = 1'b0;
    chk("ign_one_ready", 32'(n_rdy), 32'd1);
    chk("ign_busy_span", 32'(busy_ok), 32'd1);
    acc_a("rd24", 1'b1, 1'b0, 32'h24, 32'h0, 32'h2424_2424, 1'b0);

    // Zero-wait instance: back-to-back streams.
    stream_b("w0_wr", 1'b1, 32'h1111_0000, 32'h2222_0004, 32'h3333_0008,
             32'h0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    stream_b("w0_rd", 1'b0, 32'h0, 32'h0, 32'h0,
             32'h1111_0000, 32'h2222_0004, 32'h3333_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's data port (`mRD`/`mWR`/`DAddr`/`DataIn`/`DataOut`). It latches one read or write request, inserts a programmable number of wait states, and then completes the access with a one-cycle `Ready` pulse. The block replaces the zero-wait combinational data memory, so the control unit's MEM state must hold until `Ready` is seen.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; must be a power of two, at least 2.
- `WAIT_CYCLES`, 2: wait states inserted between request capture and response, range 0..15.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `mRD`  in  1  read request.
- `mWR`  in  1  write request; wins over `mRD` if both are high.
- `DAddr`  in  32  byte address.
- `DataIn`  in  32  write data.
- `DataOut`  out  32  registered read data.
- `Ready`  out  1  completion pulse, one cycle long.
- `Busy`  out  1  high in WAIT and RESP.
- `Err`  out  1  misaligned-access flag; see Configuration.

## Operation
- State machine: IDLE, WAIT, RESP.
- **IDLE**
  - On an edge with `mRD|mWR` high, latch `DAddr`, `DataIn` and the op (write if `mWR` is high).
  - Load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT, or RESP directly if `WAIT_CYCLES==0`.
  - With no request, stay in IDLE.
- **WAIT**
  - Decrement the counter each edge.
  - Move to RESP on the edge where the counter equals 1.
  - Request inputs are ignored.
- **RESP**
  - `Ready=1` for exactly this cycle; next state is IDLE unconditionally.
  - Request inputs are ignored.
- **Access commit** happens on the edge that enters RESP:
  - Word index = latched `DAddr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
  - Write: `mem[index] <= latched DataIn`. `DataOut` is unchanged.
  - Read: `DataOut <= mem[index]`. The value holds until the next completed read.
- Inputs are latched, so the requester may drop `mRD`/`mWR` after capture.
- A request still high in the IDLE cycle after RESP is captured again as a new access. The CPU must deassert its request on `Ready`.
- Memory array contents are not reset.

## Timing
- Reset (asynchronous assert): state IDLE, counter 0, `DataOut=0`, `Ready=0`, `Busy=0`, `Err=0`.
- Reset mid-operation aborts the access. A pending write is discarded and the memory is not modified.
- Request captured at edge k ⇒ `Ready` is high in the cycle following edge k+`WAIT_CYCLES`.
  - `WAIT_CYCLES=0`: `Ready` in the cycle after the capture edge.
- Minimum spacing between captures is `WAIT_CYCLES`+2 edges. Back-to-back throughput is one access per `WAIT_CYCLES`+2 cycles.
- `Busy` rises in the cycle after capture and falls when IDLE is re-entered.
- `Err` is valid only while `Ready` is high; otherwise it is 0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - An access whose latched `DAddr[1:0]!=0` completes normally in timing, with `Err=1` alongside `Ready`.
  - A misaligned write is suppressed (memory unchanged).
  - A misaligned read leaves `DataOut` unchanged.
- Not defined:
  - `Err` is tied to 0.
  - `DAddr[1:0]` is ignored and every access is treated as aligned.

## Test plan
- `WAIT_CYCLES=2`: write 0xDEADBEEF to 0x08, then read 0x08 ⇒ `Ready` 3 cycles after each capture and `DataOut=0xDEADBEEF` during the read's RESP cycle. `DataOut` must not change during the write.
- `WAIT_CYCLES=0`: reads of 0x00, 0x04, 0x08 held continuously high ⇒ `Ready` every 2nd cycle, returning the three previously written words in order.
- `DEPTH_WORDS=64`: write 0x12345678 to 0x100, read 0x000 ⇒ 0x12345678 (wrap-around). `mRD=mWR=1` with 0xA5A5A5A5 ⇒ treated as a write, `DataOut` unchanged.
- Reset pulled low in WAIT during a write of 0xFFFFFFFF to 0x10 ⇒ outputs return to 0 immediately and a later read of 0x10 returns the prior contents. `Ready` never pulses for the aborted access.
- With `DMEM_ALIGN_CHECK_EN`: write 0x11111111 to 0x0A ⇒ `Err=1` with `Ready`, and a read of 0x08 returns the old value. Without the macro: same stimulus ⇒ `Err=0` and 0x08 reads 0x11111111.
- Requests pulsed during WAIT and RESP ⇒ ignored. Exactly one `Ready` per capture, and `Busy` is high across the whole WAIT+RESP span.
